spi_master_loader: RTL
======================

// Module: spi_master_loader
// PURPOSE
//  Bus-side SPI master that drives the remote SPI slave loader's framed write protocol.
//  Accepts one 32-bit write request (addr, data) and emits 10 CS-framed bytes:
//  CMD_ADDR, A[31:24], A[23:16], A[15:8], A[7:0], CMD_DATA, D[31:24], D[23:16], D[15:8], D[7:0].
//  CS is released and reasserted around every byte; the slave consumes each byte on CS rising.
//  Used for board-to-board / test-harness program loading into a peer SoC's memory.
// PARAMETERS
//  CLK_DIV   4  clk_i cycles per SCLK half-period; must be >=4 (slave oversamples SCLK); elab assert
//  CS_GAP    8  clk_i cycles CS held high between bytes; must be >=4; elab assert
// PORTS
//  clk_i        in   1   system clock (single clock domain)
//  rst_ni       in   1   asynchronous active-low reset
//  wr_valid_i   in   1   write request valid
//  wr_ready_o   out  1   block idle, request accepted when valid&&ready
//  wr_addr_i    in   32  target address at the remote side
//  wr_data_i    in   32  target data (full word)
//  busy_o       out  1   transaction in progress
//  irq_done_o   out  1   one-cycle done pulse (SPI_MASTER_LOADER_IRQ_EN only, else tied 0)
//  sclk_o       out  1   SPI clock, mode 0 (CPOL=0, CPHA=0)
//  cs_o         out  1   chip select, active low
//  mosi_o       out  1   serial data, MSB first
//  miso_i       in   1   unused (write-only protocol); no internal logic
// BEHAVIOUR
//  Reset (async): cs_o=1, sclk_o=0, mosi_o=0, busy_o=0, wr_ready_o=1, irq_done_o=0; FSM->IDLE.
//  All SPI outputs registered, glitch-free.
//  Handshake: in IDLE, wr_ready_o=1; valid&&ready latches addr/data and byte_idx=0, FSM->CS_SETUP next cycle.
//   Ready drops the cycle after accept; valid while busy is ignored (no queue).
//  FSM: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> (byte_idx<9: CS_SETUP | byte_idx==9: IDLE).
//   CS_SETUP: cs_o=0, sclk_o=0, mosi_o=byte[7], CLK_DIV cycles.
//   SHIFT: 8 bits; each bit sclk_o high CLK_DIV cycles then low CLK_DIV cycles; mosi_o changes only
//    on SCLK falling edge (next bit); slave samples on rising edge.
//   CS_HOLD: sclk_o=0, cs_o=0, CLK_DIV cycles.
//   GAP: cs_o=1, mosi_o=0, CS_GAP cycles; byte_idx increments on exit.
//  Byte select: idx0=8'h01, idx1..4=addr MSB..LSB, idx5=8'h02, idx6..9=data MSB..LSB.
//  Per-byte time = 18*CLK_DIV + CS_GAP; full transaction = 10*(18*CLK_DIV+CS_GAP) cycles from accept
//   (defaults: 800). wr_ready_o=1 on the cycle after the final GAP completes.
//  Counters: div_cnt $clog2(CLK_DIV+CS_GAP) bits, bit_cnt 3 bits, byte_idx 4 bits; no wrap past 9.
//  Reset mid-transaction: immediate abort, cs_o high asynchronously; no partial byte is completed.
//   The slave sees an unterminated byte and drops it.
//  busy_o = (FSM != IDLE).
// CONFIGURATION
//  SPI_MASTER_LOADER_IRQ_EN defined: irq_done_o pulses high exactly 1 cycle, on the GAP->IDLE
//   transition of byte 9.
//  Not defined: irq_done_o constant 0, no extra flops.
// STRUCTURE
//  spi_loader_pkg: CMD_ADDR=8'h01, CMD_DATA=8'h02, NUM_FRAME_BYTES=10, FSM state enum.
//   Shared with the slave side so both ends use one command definition.
//  Sub-module spi_byte_tx: serialises one byte (CS_SETUP/SHIFT/CS_HOLD timing, start/done handshake).
//   The top keeps the handshake, frame sequencing, GAP timing and IRQ.
// TESTING
//  1 Reset then idle 20 cycles -> cs_o=1, sclk_o=0, mosi_o=0, wr_ready_o=1, busy_o=0.
//  2 Write addr=32'h0000_1000 data=32'hDEAD_BEEF -> bench SPI model decodes bytes
//    01,00,00,10,00,02,DE,AD,BE,EF; exactly 10 CS low pulses; 8 SCLK rises per pulse.
//  3 Same write, count cycles accept->wr_ready_o -> 800 (defaults).
//    Each SCLK high/low phase = 4 cycles; each CS gap = 8 cycles.
//  4 Assert wr_valid_i with new addr/data while busy -> ignored; frame bytes unchanged.
//    Next request accepted only when wr_ready_o=1.
//  5 Assert rst_ni low during byte 3, bit 4 -> cs_o=1, sclk_o=0 same cycle.
//    After release, a new write of 32'h1/32'h2 emits a full correct frame.
//  6 With SPI_MASTER_LOADER_IRQ_EN -> irq_done_o high exactly 1 cycle at frame end.
//    Without the macro -> irq_done_o stays 0 throughout.
//  End-to-end: pair with the slave loader in the bench; peer bus sees write of DEAD_BEEF to 0x1000,
//   size 4'b1111.

Source files
------------

// File: rtl/spi_loader_pkg.sv
// Shared definitions for the SPI loader link: command bytes, frame length,
// FSM state codes, write-request payload and the frame byte selector.
package spi_loader_pkg;

    localparam logic [7:0]  CMD_ADDR        = 8'h01;
    localparam logic [7:0]  CMD_DATA        = 8'h02;
    localparam int unsigned NUM_FRAME_BYTES = 10;
    localparam int unsigned BYTE_IDX_W      = 4;

    // Frame-level states (top)
    localparam logic [1:0] FRM_IDLE    = 2'd0;
    localparam logic [1:0] FRM_BYTE    = 2'd1;
    localparam logic [1:0] FRM_GAP     = 2'd2;

    // Byte-level states (serialiser)
    localparam logic [1:0] TX_IDLE     = 2'd0;
    localparam logic [1:0] TX_CS_SETUP = 2'd1;
    localparam logic [1:0] TX_SHIFT    = 2'd2;
    localparam logic [1:0] TX_CS_HOLD  = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_req_t;

    // Byte sent at position idx of a write frame
    function automatic logic [7:0] frame_byte(input logic [BYTE_IDX_W-1:0] idx,
                                              input wr_req_t              req);
        case (idx)
            4'd0:    frame_byte = CMD_ADDR;
            4'd1:    frame_byte = req.addr[31:24];
            4'd2:    frame_byte = req.addr[23:16];
            4'd3:    frame_byte = req.addr[15:8];
            4'd4:    frame_byte = req.addr[7:0];
            4'd5:    frame_byte = CMD_DATA;
            4'd6:    frame_byte = req.data[31:24];
            4'd7:    frame_byte = req.data[23:16];
            4'd8:    frame_byte = req.data[15:8];
            4'd9:    frame_byte = req.data[7:0];
            default: frame_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Serialises one byte as a CS-framed SPI mode-0 transfer:
// CS_SETUP (CLK_DIV) -> 8 x (SCLK high CLK_DIV, low CLK_DIV) -> CS_HOLD (CLK_DIV).
// CS rises on the edge that ends CS_HOLD, which is also when done_c_o is high.
module spi_byte_tx
    import spi_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       done_c_o,
    output logic       cs_o,
    output logic       sclk_o,
    output logic       mosi_o
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cnt_end;

    assign cnt_end = (cnt_q == CNT_W'(CLK_DIV - 1));

    // State and SPI output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    // Next-state and next-output logic; MOSI only moves on SCLK falling edges
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        done_c_o = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (start_i) begin
                    state_d = TX_CS_SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sh_d    = {byte_i[6:0], 1'b0};
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = byte_i[7];
                end
            end
            TX_CS_SETUP: begin
                if (cnt_end) begin
                    state_d = TX_SHIFT;
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_SHIFT: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        mosi_d = sh_q[7];
                        sh_d   = {sh_q[6:0], 1'b0};
                    end else if (bit_q == 3'd7) begin
                        state_d = TX_CS_HOLD;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        sclk_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_CS_HOLD: begin
                if (cnt_end) begin
                    state_d  = TX_IDLE;
                    cnt_d    = '0;
                    cs_d     = 1'b1;
                    mosi_d   = 1'b0;
                    done_c_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign cs_o   = cs_q;
    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;

endmodule

// File: rtl/spi_master_loader.sv
// Bus-side SPI master for the remote loader: one (addr, data) write becomes
// ten CS-framed bytes 01, A[31:0], 02, D[31:0], MSB first, SPI mode 0.
// Optional feature macro: SPI_MASTER_LOADER_IRQ_EN (one-cycle done pulse on irq_done_o).
module spi_master_loader
    import spi_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic        busy_o,
    output logic        irq_done_o,
    output logic        sclk_o,
    output logic        cs_o,
    output logic        mosi_o,
    input  logic        miso_i
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + CS_GAP);

    if (CLK_DIV < 4) begin : g_bad_clk_div
        $fatal(1, "spi_master_loader: CLK_DIV must be >= 4");
    end
    if (CS_GAP < 4) begin : g_bad_cs_gap
        $fatal(1, "spi_master_loader: CS_GAP must be >= 4");
    end

    // Write-only protocol: MISO is not observed
    logic unused_miso;
    assign unused_miso = miso_i;

    logic [1:0]            state_q, state_d;
    wr_req_t               req_q, req_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]      gap_q, gap_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  start_c;
    logic                  tx_done_c;
    logic [7:0]            tx_byte_c;
`ifdef SPI_MASTER_LOADER_IRQ_EN
    logic                  irq_q, irq_d;
`endif

    // Frame state, latched request and status registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FRM_IDLE;
            req_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SPI_MASTER_LOADER_IRQ_EN
            irq_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef SPI_MASTER_LOADER_IRQ_EN
            irq_q   <= irq_d;
`endif
        end
    end

    // Handshake, byte sequencing and inter-byte CS gap
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        start_c = 1'b0;
`ifdef SPI_MASTER_LOADER_IRQ_EN
        irq_d   = 1'b0;
`endif
        case (state_q)
            FRM_IDLE: begin
                if (wr_valid_i && ready_q) begin
                    req_d   = '{addr: wr_addr_i, data: wr_data_i};
                    idx_d   = '0;
                    state_d = FRM_BYTE;
                    start_c = 1'b1;
                end
            end
            FRM_BYTE: begin
                if (tx_done_c) begin
                    state_d = FRM_GAP;
                    gap_d   = '0;
                end
            end
            FRM_GAP: begin
                if (gap_q == CNT_W'(CS_GAP - 1)) begin
                    gap_d = '0;
                    if (idx_q == BYTE_IDX_W'(NUM_FRAME_BYTES - 1)) begin
                        state_d = FRM_IDLE;
`ifdef SPI_MASTER_LOADER_IRQ_EN
                        irq_d   = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + BYTE_IDX_W'(1);
                        state_d = FRM_BYTE;
                        start_c = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + CNT_W'(1);
                end
            end
            default: state_d = FRM_IDLE;
        endcase
        ready_d   = (state_d == FRM_IDLE);
        busy_d    = (state_d != FRM_IDLE);
        tx_byte_c = frame_byte(idx_d, req_d);
    end

    // Per-byte serialiser; its registers drive the SPI pins directly
    spi_byte_tx #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_byte_tx (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_c),
        .byte_i   (tx_byte_c),
        .done_c_o (tx_done_c),
        .cs_o     (cs_o),
        .sclk_o   (sclk_o),
        .mosi_o   (mosi_o)
    );

    assign wr_ready_o = ready_q;
    assign busy_o     = busy_q;
`ifdef SPI_MASTER_LOADER_IRQ_EN
    assign irq_done_o = irq_q;
`else
    assign irq_done_o = 1'b0;
`endif

endmodule
